// File: rtl/gnrc_fifo_pkg.sv
// Shared Gray/binary helpers for the dual-clock FIFO pointer controllers.
// Functions work on a GMAX-bit container; callers zero-extend and truncate.
package gnrc_fifo_pkg;

    localparam int GMAX = 32;

    function automatic logic [GMAX-1:0] bin2gray(input logic [GMAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero-extended upper bits leave the result intact.
    function automatic logic [GMAX-1:0] gray2bin(input logic [GMAX-1:0] g);
        logic [GMAX-1:0] b;
        b = '0;
        b[GMAX-1] = g[GMAX-1];
        for (int i = GMAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gnrc_bin2gray.sv
// Combinational N-bit binary-to-Gray converter.
module gnrc_bin2gray
    import gnrc_fifo_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [N-1:0] bin_i,
    output logic [N-1:0] gray_o
);

    logic [GMAX-1:0] gray_wide;

    assign gray_wide = bin2gray(GMAX'(bin_i));
    assign gray_o    = gray_wide[N-1:0];

endmodule

// File: rtl/gnrc_fifo_wptr_ctrl.sv
// Write-side pointer controller of a dual-clock FIFO: binary/Gray write pointer,
// RAM write strobe and full/almost-full/level flags against the synchronized read pointer.
module gnrc_fifo_wptr_ctrl
    import gnrc_fifo_pkg::*;
#(
    parameter int AW        = 4,
    parameter int AF_THRESH = 2**AW - 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [AW:0]   rptr_gray_i,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_waddr_o,
    output logic [AW:0]   wptr_gray_o,
    output logic          full_o,
    output logic          almost_full_o,
    output logic [AW:0]   wlevel_o,
    output logic          overflow_o
);

    localparam int        DEPTH    = 2**AW;
    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
    localparam logic [AW:0] AF_W    = AF_THRESH[AW:0];

    logic [AW:0] wbin_q, wbin_d;
    logic [AW:0] wgray_q, wgray_d;
    logic [AW:0] level_q, level_d;
    logic        full_q, full_d;
    logic        afull_q, afull_d;
    logic        ovf_q, ovf_d;
    logic        acc;
    logic [AW:0] rbin;
    logic [AW:0] rptr_full;

    assign acc = push_i & ~full_q;

    gnrc_bin2gray #(.N(AW + 1)) u_bin2gray (
        .bin_i  (wbin_d),
        .gray_o (wgray_d)
    );

    // Write pointer is one lap ahead of the read pointer when the top two Gray bits differ.
    if (AW == 1) begin : g_full_aw1
        assign rptr_full = ~rptr_gray_i;
    end else begin : g_full_awn
        assign rptr_full = {~rptr_gray_i[AW:AW-1], rptr_gray_i[AW-2:0]};
    end

    always_comb begin
        rbin     = '0;
        rbin[AW] = rptr_gray_i[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ rptr_gray_i[i];
        end
    end

    always_comb begin
        wbin_d  = wbin_q + {{AW{1'b0}}, acc};
        level_d = wbin_d - rbin;
        full_d  = (wgray_d == rptr_full);
        afull_d = (level_d >= AF_W);
        ovf_d   = push_i & full_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ram_we_o      = acc;
    assign ram_waddr_o   = wbin_q[AW-1:0];
    assign wptr_gray_o   = wgray_q;
    assign full_o        = full_q;
    assign almost_full_o = afull_q;
    assign wlevel_o      = level_q;
    assign overflow_o    = ovf_q;

    a_full_level : assert property (@(posedge clk_i) full_q == (level_q == DEPTH_W));

endmodule

// File: tb/tb_gnrc_fifo_wptr_ctrl.sv
// Directed bench for gnrc_fifo_wptr_ctrl with AW=2, AF_THRESH=3.
module tb_gnrc_fifo_wptr_ctrl;

    localparam int AW = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          push_i;
    logic [AW:0]   rptr_gray_i;
    logic          ram_we_o;
    logic [AW-1:0] ram_waddr_o;
    logic [AW:0]   wptr_gray_o;
    logic          full_o;
    logic          almost_full_o;
    logic [AW:0]   wlevel_o;
    logic          overflow_o;

    int n_checks = 0;
    int n_errors = 0;

    // Hand-written Gray sequence for a 3-bit pointer.
    logic [2:0] gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                 3'b110, 3'b111, 3'b101, 3'b100};

    gnrc_fifo_wptr_ctrl #(.AW(AW), .AF_THRESH(3)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .push_i        (push_i),
        .rptr_gray_i   (rptr_gray_i),
        .ram_we_o      (ram_we_o),
        .ram_waddr_o   (ram_waddr_o),
        .wptr_gray_o   (wptr_gray_o),
        .full_o        (full_o),
        .almost_full_o (almost_full_o),
        .wlevel_o      (wlevel_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic [2:0] g, input logic [2:0] lvl,
                               input logic af, input logic fl, input logic ovf);
        check({tag, "_gray"},  32'(wptr_gray_o),   32'(g));
        check({tag, "_level"}, 32'(wlevel_o),      32'(lvl));
        check({tag, "_af"},    32'(almost_full_o), 32'(af));
        check({tag, "_full"},  32'(full_o),        32'(fl));
        check({tag, "_ovf"},   32'(overflow_o),    32'(ovf));
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        push_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;
    endtask

    logic [2:0] prev_g;
    logic [2:0] exp_lvl_tab [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic       exp_af_tab  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       exp_fl_tab  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_i = 1'b1;
        push_i = 1'b0;
        rptr_gray_i = 3'b000;
        do_reset();
        check_flags("reset", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
        check("reset_waddr", 32'(ram_waddr_o), 32'd0);

        // Fill from empty
        for (int i = 0; i < 4; i++) begin
            push_i = 1'b1;
            #1;
            check("fill_we", 32'(ram_we_o), 32'd1);
            check("fill_waddr", 32'(ram_waddr_o), 32'(i));
            step();
            check_flags("fill", gray_tab[i+1], exp_lvl_tab[i], exp_af_tab[i], exp_fl_tab[i], 1'b0);
        end

        // Push while full is rejected
        push_i = 1'b1;
        #1;
        check("ovf_we", 32'(ram_we_o), 32'd0);
        step();
        push_i = 1'b0;
        check_flags("ovf", 3'b110, 3'd4, 1'b1, 1'b1, 1'b1);
        step();
        check_flags("ovf_end", 3'b110, 3'd4, 1'b1, 1'b1, 1'b0);

        // Read side frees one slot
        rptr_gray_i = 3'b001;
        step();
        check_flags("rd_adv", 3'b110, 3'd3, 1'b1, 1'b0, 1'b0);
        push_i = 1'b1;
        #1;
        check("rd_adv_we", 32'(ram_we_o), 32'd1);
        check("rd_adv_waddr", 32'(ram_waddr_o), 32'd0);
        step();
        push_i = 1'b0;
        check_flags("rd_adv_push", 3'b111, 3'd4, 1'b1, 1'b1, 1'b0);

        // Wrap with the read pointer lagging by two entries
        do_reset();
        prev_g = wptr_gray_o;
        for (int w = 0; w < 12; w++) begin
            rptr_gray_i = gray_tab[(w + 6) % 8];
            push_i = 1'b1;
            step();
            check("wrap_gray", 32'(wptr_gray_o), 32'(gray_tab[(w + 1) % 8]));
            check("wrap_1bit", 32'($countones(wptr_gray_o ^ prev_g)), 32'd1);
            check("wrap_full", 32'(full_o), 32'd0);
            check("wrap_level", 32'(wlevel_o), 32'd3);
            prev_g = wptr_gray_o;
        end
        push_i = 1'b0;

        // wbin=4; bring level down to 2, then push and read together
        rptr_gray_i = gray_tab[2];
        step();
        check_flags("sim_pre", 3'b110, 3'd2, 1'b0, 1'b0, 1'b0);
        push_i = 1'b1;
        rptr_gray_i = gray_tab[3];
        step();
        push_i = 1'b0;
        check_flags("sim", 3'b111, 3'd2, 1'b0, 1'b0, 1'b0);

        // Reach level 3, then reset with push held high
        push_i = 1'b1;
        step();
        check_flags("pre_rst", 3'b101, 3'd3, 1'b1, 1'b0, 1'b0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        push_i = 1'b0;
        check_flags("mid_rst", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
        check("mid_rst_waddr", 32'(ram_waddr_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
